// File: rtl/btn_event.sv
`default_nettype none
// ============================================================================
// Module   : btn_event
// Purpose  : Turns a debounced button level into single-cycle press, release,
//            click, long-press and optional auto-repeat event pulses.
// Options  : define BTN_EVENT_REPEAT_EN to compile in the auto-repeat path.
// Revision : 1.0 - initial release
// ============================================================================
module btn_event #(
    parameter int  CLK_HZ      = 100_000_000,
    parameter real LONG_TIME   = 1.000,
    parameter real REPEAT_TIME = 0.200
) (
    input  logic clk,
    input  logic reset_n,
    input  logic db,
    output logic press_tick,
    output logic release_tick,
    output logic click_tick,
    output logic long_tick,
    output logic repeat_tick,
    output logic held
);

    // $rtoi truncates toward zero, unlike a plain int cast, which rounds.
    localparam int LONG_CYC = $rtoi(real'(CLK_HZ) * LONG_TIME);
`ifdef BTN_EVENT_REPEAT_EN
    localparam int REP_CYC  = $rtoi(real'(CLK_HZ) * REPEAT_TIME);
    localparam int MAX_CYC  = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
`else
    localparam int MAX_CYC  = LONG_CYC;
`endif
    localparam int CW = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
`ifdef BTN_EVENT_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYC - 1);
`endif

    generate
        if (LONG_CYC < 2) begin : g_bad_long
            $error("btn_event: LONG_CYC must be at least 2");
        end
`ifdef BTN_EVENT_REPEAT_EN
        if (REP_CYC < 2) begin : g_bad_rep
            $error("btn_event: REP_CYC must be at least 2");
        end
`endif
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_LONG  = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
`ifdef BTN_EVENT_REPEAT_EN
    logic            repeat_q;
    assign repeat_tick = repeat_q;
`else
    assign repeat_tick = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            press_tick   <= 1'b0;
            release_tick <= 1'b0;
            click_tick   <= 1'b0;
            long_tick    <= 1'b0;
            held         <= 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
            repeat_q     <= 1'b0;
`endif
        end else begin
            press_tick   <= 1'b0;
            release_tick <= 1'b0;
            click_tick   <= 1'b0;
            long_tick    <= 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
            repeat_q     <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (db) begin
                        state_q    <= S_PRESS;
                        press_tick <= 1'b1;
                        held       <= 1'b1;
                    end
                end
                S_PRESS: begin
                    // Release is checked first so it wins over the long threshold.
                    if (!db) begin
                        state_q      <= S_IDLE;
                        release_tick <= 1'b1;
                        click_tick   <= 1'b1;
                        held         <= 1'b0;
                        cnt_q        <= '0;
                    end else if (cnt_q == LONG_LAST) begin
                        state_q   <= S_LONG;
                        long_tick <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_LONG: begin
                    if (!db) begin
                        state_q      <= S_IDLE;
                        release_tick <= 1'b1;
                        held         <= 1'b0;
                        cnt_q        <= '0;
                    end else begin
`ifdef BTN_EVENT_REPEAT_EN
                        if (cnt_q == REP_LAST) begin
                            repeat_q <= 1'b1;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
`else
                        cnt_q <= '0;
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    held    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
